// File: rtl/tic_tac_toe.sv
// rtl/tic_tac_toe.sv - two-party tic-tac-toe controller with move legality and win/draw detection
module tic_tac_toe (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic [3:0]  player_pos,
    input  logic [3:0]  comp_pos,
    output logic        who1,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        turn,
    output logic [17:0] board
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PLAYER_TURN = 2'd1,
        COMP_TURN   = 2'd2,
        GAME_OVER   = 2'd3
    } state_t;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    state_t      state;
    logic [3:0]  prev_player;
    logic [3:0]  prev_comp;

    logic [3:0]  move_pos;
    logic [1:0]  mark;
    logic        move_seen;
    logic        move_legal;
    logic [17:0] next_board;
    logic        board_full;
    logic        line_done;

    // True when cells a, b and c (0-based) of board b_in all hold mark m
    function automatic logic owns3(input logic [17:0] b_in, input logic [1:0] m,
                                   input int a, input int b, input int c);
        return (b_in[2*a +: 2] == m) && (b_in[2*b +: 2] == m) && (b_in[2*c +: 2] == m);
    endfunction

    // Detect the active side's move, check legality and evaluate the board it would produce
    always_comb begin
        move_pos   = (state == COMP_TURN) ? comp_pos : player_pos;
        mark       = (state == COMP_TURN) ? MARK_O : MARK_X;
        move_seen  = ((state == PLAYER_TURN) && (player_pos != prev_player)) ||
                     ((state == COMP_TURN)   && (comp_pos   != prev_comp));
        move_legal = 1'b0;
        next_board = board;
        // Only values 1..9 can match a cell, so out-of-range positions are never legal
        for (int i = 0; i < 9; i++) begin
            if ((move_pos == 4'(i + 1)) && (board[2*i +: 2] == 2'b00)) begin
                move_legal           = move_seen;
                next_board[2*i +: 2] = mark;
            end
        end
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (next_board[2*i +: 2] == 2'b00) begin
                board_full = 1'b0;
            end
        end
        line_done = owns3(next_board, mark, 0, 1, 2) | owns3(next_board, mark, 3, 4, 5) |
                    owns3(next_board, mark, 6, 7, 8) | owns3(next_board, mark, 0, 3, 6) |
                    owns3(next_board, mark, 1, 4, 7) | owns3(next_board, mark, 2, 5, 8) |
                    owns3(next_board, mark, 0, 4, 8) | owns3(next_board, mark, 2, 4, 6);
    end

    // Game FSM: board, turn and result registers; prev registers track both inputs every edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            board       <= '0;
            winner      <= 2'b00;
            who1        <= 1'b0;
            game_over   <= 1'b0;
            turn        <= 1'b0;
            prev_player <= '0;
            prev_comp   <= '0;
        end else begin
            prev_player <= player_pos;
            prev_comp   <= comp_pos;
            case (state)
                IDLE, GAME_OVER: begin
                    if (play) begin
                        state     <= PLAYER_TURN;
                        board     <= '0;
                        winner    <= 2'b00;
                        who1      <= 1'b0;
                        game_over <= 1'b0;
                        turn      <= 1'b0;
                    end
                end
                PLAYER_TURN, COMP_TURN: begin
                    if (move_legal) begin
                        board <= next_board;
                        if (line_done) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= (state == PLAYER_TURN) ? 2'b01 : 2'b10;
                            who1      <= (state == PLAYER_TURN);
                        end else if (board_full) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= 2'b11;
                            who1      <= 1'b0;
                        end else begin
                            state <= (state == PLAYER_TURN) ? COMP_TURN : PLAYER_TURN;
                            turn  <= (state == PLAYER_TURN);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tic_tac_toe.sv
// tb/tb_tic_tac_toe.sv - vector table, corner sequences and random play against a reference model
module tb_tic_tac_toe;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic [3:0]  player_pos;
    logic [3:0]  comp_pos;
    logic        who1;
    logic [1:0]  winner;
    logic        game_over;
    logic        turn;
    logic [17:0] board;

    int tests = 0;
    int fails = 0;

    tic_tac_toe dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .player_pos (player_pos),
        .comp_pos   (comp_pos),
        .who1       (who1),
        .winner     (winner),
        .game_over  (game_over),
        .turn       (turn),
        .board      (board)
    );

    always #5 clk = ~clk;

    // Reference model: cells 0 empty / 1 X / 2 O; phase 0 idle, 1 player, 2 computer, 3 over
    int m_cell [9];
    int m_phase;
    int m_prev_p, m_prev_c;
    int m_win;
    bit m_who, m_over, m_turn;

    function automatic int line_cell(int l, int k);
        int t [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
        return t[l*3 + k];
    endfunction

    function automatic bit has_line(int m);
        for (int l = 0; l < 8; l++)
            if (m_cell[line_cell(l,0)] == m && m_cell[line_cell(l,1)] == m && m_cell[line_cell(l,2)] == m)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_phase = 0; m_prev_p = 0; m_prev_c = 0;
        m_win = 0; m_who = 0; m_over = 0; m_turn = 0;
    endtask

    task automatic model_edge(bit p, int pp, int cp);
        int pos, prv, me, empties;
        if (m_phase == 0 || m_phase == 3) begin
            if (p) begin
                for (int i = 0; i < 9; i++) m_cell[i] = 0;
                m_phase = 1; m_win = 0; m_who = 0; m_over = 0; m_turn = 0;
            end
        end else begin
            pos = (m_phase == 1) ? pp : cp;
            prv = (m_phase == 1) ? m_prev_p : m_prev_c;
            me  = m_phase;
            if (pos != prv && pos >= 1 && pos <= 9 && m_cell[pos-1] == 0) begin
                m_cell[pos-1] = me;
                empties = 0;
                for (int i = 0; i < 9; i++) if (m_cell[i] == 0) empties++;
                if (has_line(me)) begin
                    m_phase = 3; m_over = 1; m_win = me; m_who = (me == 1);
                end else if (empties == 0) begin
                    m_phase = 3; m_over = 1; m_win = 3; m_who = 0;
                end else begin
                    m_phase = 3 - me; m_turn = (me == 1);
                end
            end
        end
        m_prev_p = pp; m_prev_c = cp;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("board", 32'(board), 32'(model_board()));
        check("winner", 32'(winner), 32'(m_win));
        check("who1", 32'(who1), 32'(m_who));
        check("game_over", 32'(game_over), 32'(m_over));
        if (m_phase == 1 || m_phase == 2) check("turn", 32'(turn), 32'(m_turn));
    endtask

    task automatic step(bit p, logic [3:0] pp, logic [3:0] cp);
        @(negedge clk);
        play = p; player_pos = pp; comp_pos = cp;
        @(posedge clk);
        model_edge(p, int'(pp), int'(cp));
        #1;
        compare_model();
    endtask

    task automatic release_reset();
        play = 0; player_pos = 0; comp_pos = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        play;
        logic [3:0]  pp;
        logic [3:0]  cp;
        logic [1:0]  win;
        logic        who;
        logic        go;
        logic        tchk;
        logic        turn;
        logic        bchk;
        logic [17:0] bexp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic p, logic [3:0] pp, logic [3:0] cp, logic [1:0] w, logic wh,
                       logic go, logic tchk, logic t, logic bchk, logic [17:0] bexp);
        vec_t v;
        v.play = p; v.pp = pp; v.cp = cp; v.win = w; v.who = wh; v.go = go;
        v.tchk = tchk; v.turn = t; v.bchk = bchk; v.bexp = bexp;
        vecs.push_back(v);
    endtask

    initial begin
        // Draw game
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, '0);
        add(0, 5, 0, 0, 0, 0, 1, 1, 0, '0);
        add(0, 5, 1, 0, 0, 0, 1, 0, 0, '0);
        add(0, 7, 1, 0, 0, 0, 1, 1, 0, '0);
        add(0, 7, 3, 0, 0, 0, 1, 0, 0, '0);
        add(0, 2, 3, 0, 0, 0, 1, 1, 0, '0);
        add(0, 2, 8, 0, 0, 0, 1, 0, 0, '0);
        add(0, 9, 8, 0, 0, 0, 1, 1, 0, '0);
        add(0, 9, 4, 0, 0, 0, 1, 0, 0, '0);
        add(0, 6, 4, 2'b11, 0, 1, 0, 0, 1, 18'b01_10_01_01_01_10_10_01_10);
        // Player win, then a computer input change after game over
        add(1, 6, 0, 0, 0, 0, 1, 0, 1, '0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, '0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, '0);
        add(0, 2, 4, 0, 0, 0, 1, 1, 0, '0);
        add(0, 2, 5, 0, 0, 0, 1, 0, 0, '0);
        add(0, 3, 5, 2'b01, 1, 1, 0, 0, 0, '0);
        add(0, 3, 7, 2'b01, 1, 1, 0, 0, 1, 18'b00_00_00_00_10_10_01_01_01);
        // Restart, then computer win on the main diagonal
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, '0);
        add(0, 2, 0, 0, 0, 0, 1, 1, 0, '0);
        add(0, 2, 1, 0, 0, 0, 1, 0, 0, '0);
        add(0, 3, 1, 0, 0, 0, 1, 1, 0, '0);
        add(0, 3, 5, 0, 0, 0, 1, 0, 0, '0);
        add(0, 4, 5, 0, 0, 0, 1, 1, 0, '0);
        add(0, 4, 9, 2'b10, 0, 1, 0, 0, 1, 18'b10_00_00_00_10_01_01_01_10);
        // Illegal computer moves, held inputs, ignored inactive side, simultaneous change
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, '0);
        add(0, 5, 0, 0, 0, 0, 1, 1, 0, '0);
        add(0, 5, 5, 0, 0, 0, 1, 1, 0, '0);
        add(0, 5, 0, 0, 0, 0, 1, 1, 0, '0);
        add(0, 5, 12, 0, 0, 0, 1, 1, 1, 18'b00_00_00_00_01_00_00_00_00);
        add(0, 5, 6, 0, 0, 0, 1, 0, 1, 18'b00_00_00_10_01_00_00_00_00);
        add(0, 5, 6, 0, 0, 0, 1, 0, 0, '0);
        add(1, 1, 6, 0, 0, 0, 1, 1, 0, '0);
        add(0, 2, 6, 0, 0, 0, 1, 1, 0, '0);
        add(0, 2, 7, 0, 0, 0, 1, 0, 0, '0);
        add(0, 3, 8, 0, 0, 0, 1, 1, 1, 18'b00_00_10_10_01_00_01_00_01);

        rst = 1'b0; play = 0; player_pos = 0; comp_pos = 0;
        model_reset();
        #3;
        check("rst_board", 32'(board), 0);
        check("rst_winner", 32'(winner), 0);
        check("rst_who1", 32'(who1), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_turn", 32'(turn), 0);
        release_reset();

        // Inputs wiggling in IDLE must not touch the board
        step(0, 3, 7);
        step(0, 9, 2);
        step(0, 4, 4);

        foreach (vecs[i]) begin
            step(vecs[i].play, vecs[i].pp, vecs[i].cp);
            check($sformatf("vec%0d_winner", i), 32'(winner), 32'(vecs[i].win));
            check($sformatf("vec%0d_who1", i), 32'(who1), 32'(vecs[i].who));
            check($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(vecs[i].go));
            if (vecs[i].tchk) check($sformatf("vec%0d_turn", i), 32'(turn), 32'(vecs[i].turn));
            if (vecs[i].bchk) check($sformatf("vec%0d_board", i), 32'(board), 32'(vecs[i].bexp));
        end

        // Asynchronous reset mid-game, checked before any further clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_board", 32'(board), 0);
        check("async_turn", 32'(turn), 0);
        check("async_winner", 32'(winner), 0);
        check("async_game_over", 32'(game_over), 0);
        model_reset();
        release_reset();
        step(0, 0, 0);

        // Random play against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic       p;
            logic [3:0] pp, cp;
            p  = ($urandom_range(0, 15) == 0);
            pp = ($urandom_range(0, 1) == 0) ? player_pos : 4'($urandom_range(0, 11));
            cp = ($urandom_range(0, 1) == 0) ? comp_pos   : 4'($urandom_range(0, 11));
            step(p, pp, cp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
